// File: rtl/sfp_tx_sched_pkg.sv
// Shared types and constants for the sfp_tx_sched frame scheduler.
package sfp_tx_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam int unsigned STAT_W = 32;

endpackage

// File: rtl/sfp_tx_sched_rr_arbiter.sv
// Rotating-priority select: first requester found searching cyclically from last_grant+1.
module rr_arbiter
    import sfp_tx_sched_pkg::*;
#(
    parameter int unsigned PORTS = 4,
    localparam int unsigned IDX_W = $clog2(PORTS)
) (
    input  logic [PORTS-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] grant,
    output logic             found
);

    logic [31:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= PORTS; k++) begin
            idx = (32'(last_grant) + k) % PORTS;
            if (!found && req[IDX_W'(idx)]) begin
                found = 1'b1;
                grant = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/sfp_tx_sched.sv
// Frame-granular round-robin scheduler sharing one AXI-stream TX path among PORTS sources.
// Per-port completed-frame counters are built only when SFP_TX_SCHED_STATS_EN is defined.
module sfp_tx_sched
    import sfp_tx_sched_pkg::*;
#(
    parameter int unsigned PORTS      = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    localparam int unsigned IDX_W     = $clog2(PORTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [PORTS*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [PORTS-1:0]            s_axis_tvalid,
    output logic [PORTS-1:0]            s_axis_tready,
    input  logic [PORTS-1:0]            s_axis_tlast,
    input  logic [PORTS-1:0]            s_axis_tuser,
    input  logic [PORTS-1:0]            port_enable,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]       m_axis_tkeep,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic                        m_axis_tuser,
    output logic                        grant_valid,
    output logic [IDX_W-1:0]            grant_port,
    output logic [PORTS*STAT_W-1:0]     stat_frame_count
);

    state_t                  state;
    state_t                  state_nxt;
    logic [IDX_W-1:0]        last_grant;
    logic [IDX_W-1:0]        arb_grant;
    logic                    arb_found;
    logic [PORTS-1:0]        req;
    logic                    out_free;
    logic                    beat_acc;
    logic                    frame_end;
    logic                    grant_load;
    logic                    sel_valid;
    logic                    sel_last;
    logic                    sel_user;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic [KEEP_WIDTH-1:0]   sel_keep;

    assign req       = s_axis_tvalid & port_enable;
    // Output slot can take a beat if empty or draining this cycle.
    assign out_free  = m_axis_tready | ~m_axis_tvalid;
    assign beat_acc  = (state == XFER) & sel_valid & out_free;
    assign frame_end = beat_acc & sel_last;

    rr_arbiter #(
        .PORTS (PORTS)
    ) u_arb (
        .req        (req),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .found      (arb_found)
    );

    // Source mux for the currently granted port.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_user  = 1'b0;
        sel_data  = '0;
        sel_keep  = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            if (grant_port == IDX_W'(i)) begin
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
                sel_user  = s_axis_tuser[i];
                sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_keep  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        s_axis_tready = '0;
        grant_load    = 1'b0;
        case (state)
            IDLE: begin
                if (arb_found) begin
                    state_nxt  = XFER;
                    grant_load = 1'b1;
                end
            end
            XFER: begin
                s_axis_tready[grant_port] = out_free;
                if (frame_end) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant bookkeeping; last_grant moves only at frame completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_valid <= 1'b0;
            grant_port  <= '0;
            last_grant  <= IDX_W'(PORTS - 1);
        end else if (grant_load) begin
            grant_valid <= 1'b1;
            grant_port  <= arb_grant;
        end else if (frame_end) begin
            grant_valid <= 1'b0;
            last_grant  <= grant_port;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end else if (beat_acc) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= sel_data;
            m_axis_tkeep  <= sel_keep;
            m_axis_tlast  <= sel_last;
            m_axis_tuser  <= sel_user;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

`ifdef SFP_TX_SCHED_STATS_EN
    logic [STAT_W-1:0] frame_cnt [PORTS];

    // Bad frames (tuser) are counted as well; counters wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < PORTS; i++) begin
                frame_cnt[i] <= '0;
            end
        end else if (frame_end) begin
            frame_cnt[grant_port] <= frame_cnt[grant_port] + STAT_W'(1);
        end
    end

    always_comb begin
        stat_frame_count = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            stat_frame_count[i*STAT_W +: STAT_W] = frame_cnt[i];
        end
    end
`else
    assign stat_frame_count = '0;
`endif

endmodule

// File: tb/tb_sfp_tx_sched.sv
// Self-checking bench for sfp_tx_sched: randomized sources and sink against a frame-level model.
module tb_sfp_tx_sched;

    localparam int PORTS = 4;
    localparam int DW    = 64;
    localparam int KW    = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          user;
    } beat_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [PORTS*DW-1:0]   s_axis_tdata = '0;
    logic [PORTS*KW-1:0]   s_axis_tkeep = '0;
    logic [PORTS-1:0]      s_axis_tvalid = '0;
    logic [PORTS-1:0]      s_axis_tready;
    logic [PORTS-1:0]      s_axis_tlast = '0;
    logic [PORTS-1:0]      s_axis_tuser = '0;
    logic [PORTS-1:0]      port_enable = '1;
    logic [DW-1:0]         m_axis_tdata;
    logic [KW-1:0]         m_axis_tkeep;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready = 1'b0;
    logic                  m_axis_tlast;
    logic                  m_axis_tuser;
    logic                  grant_valid;
    logic [1:0]            grant_port;
    logic [PORTS*32-1:0]   stat_frame_count;

    sfp_tx_sched dut (
        .clk              (clk),
        .rst              (rst),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tkeep     (s_axis_tkeep),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_tuser     (s_axis_tuser),
        .port_enable      (port_enable),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tkeep     (m_axis_tkeep),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tuser     (m_axis_tuser),
        .grant_valid      (grant_valid),
        .grant_port       (grant_port),
        .stat_frame_count (stat_frame_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Sources and stimulus knobs
    beat_t            srcq [PORTS][$];
    beat_t            sent [PORTS][$];
    logic [PORTS-1:0] en = '1;
    int               vprob = 100;
    int               rmode = 0;
    bit               tog   = 1'b0;

    // Reference model of the scheduler
    bit    m_busy;
    int    m_port;
    int    m_last;
    bit    m_ovalid;
    beat_t m_obeat;

    // Observations at the sink
    int    obs_grants [$];
    beat_t obs_beat [$];
    int    obs_cyc [$];
    bit    prev_gv;

    function automatic int rr_pick(input logic [PORTS-1:0] r, input int last);
        for (int k = 1; k <= PORTS; k++) begin
            if (r[(last + k) % PORTS]) return (last + k) % PORTS;
        end
        return -1;
    endfunction

    function automatic bit tb_idle();
        if (m_busy || m_ovalid) return 1'b0;
        for (int p = 0; p < PORTS; p++) begin
            if (en[p] && srcq[p].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int beat_port(input beat_t b);
        return int'(b.data[DW-1:DW-8]);
    endfunction

    task automatic push_frame(input int p, input int len, input int fid);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = {8'(p), 8'(fid), 16'(i), 32'($urandom)};
            b.keep = 8'($urandom);
            b.last = (i == len - 1);
            b.user = b.last ? 1'($urandom) : 1'b0;
            srcq[p].push_back(b);
            sent[p].push_back(b);
        end
    endtask

    task automatic apply_reset();
        rst           = 1'b1;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = '0;
        s_axis_tuser  = '0;
        m_axis_tready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_busy = 1'b0; m_port = 0; m_last = PORTS - 1; m_ovalid = 1'b0; m_obeat = '0;
        for (int p = 0; p < PORTS; p++) begin
            srcq[p].delete();
            sent[p].delete();
        end
        obs_grants.delete(); obs_beat.delete(); obs_cyc.delete();
        prev_gv = 1'b0;
        en = '1; vprob = 100; rmode = 0; tog = 1'b0;
    endtask

    // One clock: drive at negedge, compare against the model, then advance the model.
    task automatic run_cycle();
        logic [PORTS-1:0] vld;
        logic [PORTS-1:0] exp_rdy;
        bit               acc_m;
        bit               old_busy;
        int               pick;
        beat_t            b;
        @(negedge clk);
        cyc++;
        for (int p = 0; p < PORTS; p++) begin
            vld[p] = (srcq[p].size() != 0) && ($urandom_range(99) < vprob);
            b = (srcq[p].size() != 0) ? srcq[p][0] : '0;
            s_axis_tdata[p*DW +: DW] = b.data;
            s_axis_tkeep[p*KW +: KW] = b.keep;
            s_axis_tlast[p]          = b.last;
            s_axis_tuser[p]          = b.user;
        end
        s_axis_tvalid = vld;
        port_enable   = en;
        case (rmode)
            0:       m_axis_tready = 1'b1;
            1:       begin tog = !tog; m_axis_tready = tog; end
            default: m_axis_tready = 1'($urandom_range(1));
        endcase
        #1;
        checks++;
        if (m_axis_tvalid !== m_ovalid) begin
            errors++;
            $display("FAIL m_tvalid cyc=%0d got=%0b exp=%0b", cyc, m_axis_tvalid, m_ovalid);
        end
        if (m_ovalid) begin
            checks++;
            if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} !== m_obeat) begin
                errors++;
                $display("FAIL m_beat cyc=%0d got=%h/%h/%0b/%0b exp=%h/%h/%0b/%0b", cyc,
                         m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser,
                         m_obeat.data, m_obeat.keep, m_obeat.last, m_obeat.user);
            end
        end
        checks++;
        if (grant_valid !== m_busy || grant_port !== 2'(m_port)) begin
            errors++;
            $display("FAIL grant cyc=%0d got=%0b/%0d exp=%0b/%0d", cyc, grant_valid, grant_port,
                     m_busy, m_port);
        end
        exp_rdy = '0;
        if (m_busy) exp_rdy[m_port] = m_axis_tready || !m_ovalid;
        checks++;
        if (s_axis_tready !== exp_rdy) begin
            errors++;
            $display("FAIL s_tready cyc=%0d got=%b exp=%b", cyc, s_axis_tready, exp_rdy);
        end
        if (grant_valid && !prev_gv) obs_grants.push_back(int'(grant_port));
        prev_gv = grant_valid;
        if (m_axis_tvalid && m_axis_tready) begin
            obs_beat.push_back({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser});
            obs_cyc.push_back(cyc);
        end
        // Model update for the coming edge
        old_busy = m_busy;
        acc_m    = m_busy && vld[m_port] && exp_rdy[m_port];
        if (acc_m) begin
            m_obeat  = srcq[m_port][0];
            m_ovalid = 1'b1;
            if (m_obeat.last) begin
                m_busy = 1'b0;
                m_last = m_port;
            end
        end else if (m_axis_tready) begin
            m_ovalid = 1'b0;
        end
        if (!old_busy) begin
            pick = rr_pick(vld & en, m_last);
            if (pick >= 0) begin
                m_busy = 1'b1;
                m_port = pick;
            end
        end
        for (int p = 0; p < PORTS; p++) begin
            if (vld[p] && s_axis_tready[p]) void'(srcq[p].pop_front());
        end
    endtask

    task automatic drain(input int budget, input string tag);
        int n;
        n = 0;
        while (!tb_idle() && n < budget) begin
            run_cycle();
            n++;
        end
        checks++;
        if (!tb_idle()) begin
            errors++;
            $display("FAIL %s drain timeout got=%0d cycles exp=idle", tag, budget);
        end
        repeat (2) run_cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== '0 || grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%0b/%b/%0b exp=0/0/0", m_axis_tvalid, s_axis_tready, grant_valid);
        end
        apply_reset();
        #1;
        checks++;
        if (m_axis_tdata !== '0 || m_axis_tkeep !== '0 || m_axis_tlast !== 1'b0 || m_axis_tuser !== 1'b0) begin
            errors++;
            $display("FAIL reset_data got=%h/%h/%0b/%0b exp=0", m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser);
        end
        checks++;
        if (grant_port !== 2'd0 || stat_frame_count !== '0) begin
            errors++;
            $display("FAIL reset_grant_stats got=%0d/%h exp=0/0", grant_port, stat_frame_count);
        end
    endtask

    task automatic test_single_frame();
        apply_reset();
        push_frame(0, 3, 1);
        drain(50, "single");
        checks++;
        if (obs_beat.size() != 3) begin
            errors++;
            $display("FAIL single_count got=%0d exp=3", obs_beat.size());
        end else begin
            checks++;
            if (obs_cyc[1] - obs_cyc[0] != 1 || obs_cyc[2] - obs_cyc[1] != 1) begin
                errors++;
                $display("FAIL single_spacing got=%0d,%0d exp=1,1", obs_cyc[1] - obs_cyc[0], obs_cyc[2] - obs_cyc[1]);
            end
            checks++;
            if ({obs_beat[0].last, obs_beat[1].last, obs_beat[2].last} !== 3'b001) begin
                errors++;
                $display("FAIL single_tlast got=%b exp=001", {obs_beat[0].last, obs_beat[1].last, obs_beat[2].last});
            end
        end
        checks++;
        if (obs_grants.size() != 1 || obs_grants[0] != 0) begin
            errors++;
            $display("FAIL single_grant got=%0d grants exp=1 grant of port 0", obs_grants.size());
        end
    endtask

    task automatic test_round_robin();
        int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int firsts [$];
        apply_reset();
        for (int f = 0; f < 2; f++)
            for (int p = 0; p < PORTS; p++) push_frame(p, 2, f);
        drain(100, "rr");
        checks++;
        if (obs_grants.size() != 8) begin
            errors++;
            $display("FAIL rr_grant_count got=%0d exp=8", obs_grants.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (obs_grants[i] != exp_order[i]) begin
                    errors++;
                    $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i, obs_grants[i], exp_order[i]);
                end
            end
        end
        for (int i = 0; i < obs_beat.size(); i++)
            if (i == 0 || obs_beat[i-1].last) firsts.push_back(obs_cyc[i]);
        for (int i = 1; i < firsts.size(); i++) begin
            checks++;
            if (firsts[i] - firsts[i-1] != 3) begin
                errors++;
                $display("FAIL rr_frame_gap idx=%0d got=%0d exp=3", i, firsts[i] - firsts[i-1]);
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        push_frame(2, 6, 7);
        rmode = 1;
        drain(100, "bp");
        checks++;
        if (obs_beat.size() != 6) begin
            errors++;
            $display("FAIL bp_count got=%0d exp=6", obs_beat.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (obs_beat[i] !== sent[2][i]) begin
                    errors++;
                    $display("FAIL bp_beat idx=%0d got=%h exp=%h", i, obs_beat[i], sent[2][i]);
                end
            end
        end
    endtask

    task automatic test_port_disable();
        int n;
        int p1_beats;
        int p1_grants;
        bit p1_last;
        apply_reset();
        push_frame(1, 4, 1);
        push_frame(1, 2, 2);
        push_frame(2, 2, 1);
        push_frame(2, 2, 2);
        n = 0;
        while (obs_beat.size() < 1 && n < 20) begin
            run_cycle();
            n++;
        end
        en[1] = 1'b0;
        drain(100, "disable");
        p1_beats = 0; p1_last = 1'b0; p1_grants = 0;
        foreach (obs_beat[i]) if (beat_port(obs_beat[i]) == 1) begin
            p1_beats++;
            p1_last = obs_beat[i].last;
        end
        foreach (obs_grants[i]) if (obs_grants[i] == 1) p1_grants++;
        checks++;
        if (p1_beats != 4 || p1_last !== 1'b1) begin
            errors++;
            $display("FAIL disable_complete got=%0d beats last=%0b exp=4 beats last=1", p1_beats, p1_last);
        end
        checks++;
        if (p1_grants != 1 || srcq[1].size() != 2) begin
            errors++;
            $display("FAIL disable_no_grant got=%0d grants %0d left exp=1 grant 2 left", p1_grants, srcq[1].size());
        end
        en = '1;
        drain(100, "reenable");
    endtask

    task automatic test_reset_midframe();
        int n;
        apply_reset();
        push_frame(1, 5, 3);
        n = 0;
        while (obs_beat.size() < 2 && n < 20) begin
            run_cycle();
            n++;
        end
        checks++;
        if (obs_beat.size() < 2) begin
            errors++;
            $display("FAIL midrst_setup got=%0d beats exp=2", obs_beat.size());
        end
        rst = 1'b1;
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || m_axis_tlast !== 1'b0 ||
            s_axis_tready !== '0 || grant_valid !== 1'b0 || grant_port !== 2'd0) begin
            errors++;
            $display("FAIL midrst_async got=%0b/%h/%b/%0b/%0d exp=all 0", m_axis_tvalid, m_axis_tdata,
                     s_axis_tready, grant_valid, grant_port);
        end
        apply_reset();
        for (int p = 0; p < PORTS; p++) push_frame(p, 2, 9);
        n = 0;
        while (obs_grants.size() < 1 && n < 20) begin
            run_cycle();
            n++;
        end
        checks++;
        if (obs_grants.size() < 1 || obs_grants[0] != 0) begin
            errors++;
            $display("FAIL midrst_priority got=%0d grants first=%0d exp=port 0", obs_grants.size(),
                     (obs_grants.size() > 0) ? obs_grants[0] : -1);
        end
        drain(100, "midrst");
    endtask

    task automatic test_random();
        int  total;
        bit  interleaved;
        beat_t got [$];
        apply_reset();
        total = 0;
        for (int f = 0; f < 25; f++) begin
            int p = $urandom_range(PORTS - 1);
            int len = $urandom_range(6, 1);
            push_frame(p, len, f);
            total += len;
        end
        vprob = 60;
        rmode = 2;
        drain(3000, "random");
        checks++;
        if (obs_beat.size() != total) begin
            errors++;
            $display("FAIL random_count got=%0d exp=%0d", obs_beat.size(), total);
        end
        interleaved = 1'b0;
        for (int i = 1; i < obs_beat.size(); i++)
            if (!obs_beat[i-1].last && beat_port(obs_beat[i]) != beat_port(obs_beat[i-1])) interleaved = 1'b1;
        checks++;
        if (interleaved) begin
            errors++;
            $display("FAIL random_interleave got=interleaved exp=whole frames");
        end
        for (int p = 0; p < PORTS; p++) begin
            got.delete();
            foreach (obs_beat[i]) if (beat_port(obs_beat[i]) == p) got.push_back(obs_beat[i]);
            checks++;
            if (got.size() != sent[p].size()) begin
                errors++;
                $display("FAIL random_port_len port=%0d got=%0d exp=%0d", p, got.size(), sent[p].size());
            end else begin
                foreach (got[i]) if (got[i] !== sent[p][i]) begin
                    errors++;
                    $display("FAIL random_port_data port=%0d idx=%0d got=%h exp=%h", p, i, got[i], sent[p][i]);
                    break;
                end
            end
        end
    endtask

    task automatic test_stats();
        int exp;
        apply_reset();
        for (int f = 0; f < 5; f++) push_frame(2, $urandom_range(4, 1), f);
        drain(200, "stats");
        for (int p = 0; p < PORTS; p++) begin
`ifdef SFP_TX_SCHED_STATS_EN
            exp = (p == 2) ? 5 : 0;
`else
            exp = 0;
`endif
            checks++;
            if (stat_frame_count[p*32 +: 32] !== 32'(exp)) begin
                errors++;
                $display("FAIL stats port=%0d got=%0d exp=%0d", p, stat_frame_count[p*32 +: 32], exp);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_backpressure();
        test_port_disable();
        test_reset_midframe();
        test_random();
        test_stats();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
